// File: rtl/dma_copy_engine_pkg.sv
// dma_pkg: shared types and constants for the word copy engine.
// Defines the FSM state enum, the command bundle and the word size.
package dma_pkg;

  localparam int DMA_ADDR_WIDTH = 32;
  localparam int DMA_LEN_WIDTH  = 16;
  localparam int DMA_WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } dma_state_t;

  typedef struct packed {
    logic [DMA_ADDR_WIDTH-1:0] src;
    logic [DMA_ADDR_WIDTH-1:0] dst;
    logic [DMA_LEN_WIDTH-1:0]  len;
  } dma_cmd_t;

endpackage

// File: rtl/dma_copy_engine_if.sv
// Single-outstanding memory port between the copy engine and memory.
// master: engine (req_* out, resp_* in); slave: memory responder.
interface dma_copy_engine_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_wen;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_error;
  logic [31:0]           resp_rdata;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata,
    input  req_ready, resp_valid, resp_error, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata,
    output req_ready, resp_valid, resp_error, resp_rdata
  );

endinterface

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word memory-to-memory copy, read-then-write per word.
// Ports: clk, rst_n (async low), cmd_* command handshake, mem (memory
// port master), done pulse, err, words_done, checksum.
// Macro DMA_CHECKSUM_EN: checksum sums read data; otherwise tied to 0.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = DMA_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DMA_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  dma_copy_engine_if.master     mem,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic [31:0]           checksum
);

  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(DMA_WORD_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN =
    ~ADDR_WIDTH'(DMA_WORD_BYTES - 1);

  dma_state_t            r_state;
  dma_state_t            w_state_nx;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_words;
  logic [31:0]           r_data;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_rd_rsp;
  logic                  w_wr_rsp;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic                  w_rsp_err;
  logic [LEN_WIDTH-1:0]  w_words_inc;
  logic                  w_last;

  assign w_accept    = (r_state == S_IDLE) && cmd_valid;
  assign w_rd_rsp    = (r_state == S_RD_WAIT) && mem.resp_valid;
  assign w_wr_rsp    = (r_state == S_WR_WAIT) && mem.resp_valid;
  assign w_rd_ok     = w_rd_rsp && !mem.resp_error;
  assign w_wr_ok     = w_wr_rsp && !mem.resp_error;
  assign w_rsp_err   = (w_rd_rsp || w_wr_rsp) && mem.resp_error;
  assign w_words_inc = r_words + LEN_WIDTH'(1);
  assign w_last      = (w_words_inc == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nx = (cmd_len == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (mem.req_ready) w_state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem.resp_valid) begin
          w_state_nx = mem.resp_error ? S_DONE : S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (mem.req_ready) w_state_nx = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem.resp_valid) begin
          w_state_nx = (mem.resp_error || w_last) ?
                       S_DONE : S_RD_REQ;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Request fields come straight from registers, so they stay
  // stable for as long as a REQ state waits on req_ready.
  always_comb begin
    cmd_ready     = 1'b0;
    done          = 1'b0;
    mem.req_valid = 1'b0;
    mem.req_wen   = 1'b0;
    mem.req_addr  = r_src;
    unique case (r_state)
      S_IDLE:   cmd_ready = 1'b1;
      S_RD_REQ: mem.req_valid = 1'b1;
      S_WR_REQ: begin
        mem.req_valid = 1'b1;
        mem.req_wen   = 1'b1;
        mem.req_addr  = r_dst;
      end
      S_DONE:   done = 1'b1;
      default: ;
    endcase
  end

  assign mem.req_wdata = r_data;
  assign err           = r_err;
  assign words_done    = r_words;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_words <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (1'b1)
        w_accept: begin
          r_src   <= cmd_src & ALIGN;
          r_dst   <= cmd_dst & ALIGN;
          r_len   <= cmd_len;
          r_words <= '0;
          r_err   <= 1'b0;
        end
        w_rsp_err: r_err  <= 1'b1;
        w_rd_ok:   r_data <= mem.resp_rdata;
        w_wr_ok: begin
          r_words <= w_words_inc;
          r_src   <= r_src + STEP;
          r_dst   <= r_dst + STEP;
        end
        default: ;
      endcase
    end
  end

`ifdef DMA_CHECKSUM_EN
  logic [31:0] r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= '0;
    end else if (w_rd_ok) begin
      r_csum <= r_csum + mem.resp_rdata;
    end
  end

  assign checksum = r_csum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine: vector table plus reset corner.
// Memory model responds with programmable ready and response waits.
module tb_dma_copy_engine;
  import dma_pkg::*;

`ifdef DMA_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_src;
  logic [31:0] cmd_dst;
  logic [15:0] cmd_len;
  logic        done;
  logic        err;
  logic [15:0] words_done;
  logic [31:0] checksum;

  dma_copy_engine_if #(.ADDR_WIDTH(32)) bus ();

  dma_copy_engine #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_len    (cmd_len),
    .mem        (bus),
    .done       (done),
    .err        (err),
    .words_done (words_done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:1023];
  int rw = 0;
  int dw = 0;

  // memory responder
  bit          out_pend = 1'b0;
  int          rcnt = 0;
  int          dcnt = 0;
  logic [31:0] t_addr;
  logic        t_wen;
  logic [31:0] t_wdata;

  initial begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_error = 1'b0;
    bus.resp_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.resp_valid = 1'b0;
      bus.resp_error = 1'b0;
      if (out_pend) begin
        if (dcnt >= dw) begin
          bus.resp_valid = 1'b1;
          if (t_addr[31:16] != 16'h0) bus.resp_error = 1'b1;
          else if (t_wen) mem[t_addr[11:2]] = t_wdata;
          else bus.resp_rdata = mem[t_addr[11:2]];
          out_pend = 1'b0;
        end else begin
          dcnt++;
        end
      end
      bus.req_ready = 1'b0;
      if (bus.req_valid && !out_pend) begin
        if (rcnt >= rw) bus.req_ready = 1'b1;
        else rcnt++;
      end
      if (bus.req_valid && bus.req_ready) begin
        out_pend = 1'b1;
        dcnt     = 0;
        rcnt     = 0;
        t_addr   = bus.req_addr;
        t_wen    = bus.req_wen;
        t_wdata  = bus.req_wdata;
      end
    end
  end

  // bus monitor, sampled mid-cycle
  int          mon_reqs, mon_wrs, mon_rv, mon_done, mon_unst;
  bit          got_rd, got_wr, prev_stall;
  logic [31:0] first_rd, first_wr, p_addr, p_wdata;
  logic        p_wen;

  task automatic clear_mon();
    mon_reqs = 0; mon_wrs = 0; mon_rv = 0;
    mon_done = 0; mon_unst = 0;
    got_rd = 0; got_wr = 0; prev_stall = 0;
    first_rd = '0; first_wr = '0;
  endtask

  always @(negedge clk) begin
    if (prev_stall && (!bus.req_valid || bus.req_addr !== p_addr ||
        bus.req_wen !== p_wen || bus.req_wdata !== p_wdata))
      mon_unst++;
    prev_stall = bus.req_valid && !bus.req_ready;
    p_addr  = bus.req_addr;
    p_wen   = bus.req_wen;
    p_wdata = bus.req_wdata;
    if (bus.req_valid) mon_rv++;
    if (bus.req_valid && bus.req_ready) begin
      mon_reqs++;
      if (bus.req_wen) begin
        mon_wrs++;
        if (!got_wr) begin got_wr = 1; first_wr = bus.req_addr; end
      end else if (!got_rd) begin
        got_rd = 1; first_rd = bus.req_addr;
      end
    end
    if (done) mon_done++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_cmd(input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n);
    check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_src = s; cmd_dst = d; cmd_len = n;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done, expected done");
    end
  endtask

  typedef struct {
    logic [31:0] src, dst;
    logic [15:0] len;
    int          rw, dw;
    logic        e_err;
    int          e_words, e_reqs, e_cyc;
    logic [31:0] e_csum, e_rd0, e_wr0;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cyc;
    rst_n = 1'b0; cmd_valid = 1'b0;
    cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD0000 + i;
    for (int i = 0; i < 4; i++) mem[i] = 32'h11111111 * (i + 1);
    clear_mon();

    vecs[0] = '{32'h0, 32'h100, 16'd4, 0, 0, 1'b0, 4, 8, 17,
                32'hAAAAAAAA, 32'h0, 32'h100};
    vecs[1] = '{32'h0, 32'h200, 16'd2, 3, 3, 1'b0, 2, 4, -1,
                32'h33333333, 32'h0, 32'h200};
    vecs[2] = '{32'h0, 32'h300, 16'd0, 0, 0, 1'b0, 0, 0, 1,
                32'h0, 32'h0, 32'h0};
    vecs[3] = '{32'h00010000, 32'h400, 16'd3, 0, 0, 1'b1, 0, 1, 3,
                32'h0, 32'h00010000, 32'h0};
    vecs[4] = '{32'h3, 32'h102, 16'd1, 0, 0, 1'b0, 1, 2, 5,
                32'h11111111, 32'h0, 32'h100};

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_req_valid", {31'b0, bus.req_valid}, 32'd0);
    check("rst_req_wen", {31'b0, bus.req_wen}, 32'd0);
    check("rst_req_addr", bus.req_addr, 32'd0);
    check("rst_req_wdata", bus.req_wdata, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_words", {16'b0, words_done}, 32'd0);
    check("rst_csum", checksum, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      rw = vecs[v].rw;
      dw = vecs[v].dw;
      clear_mon();
      start_cmd(vecs[v].src, vecs[v].dst, vecs[v].len);
      wait_done(cyc);
      if (vecs[v].e_cyc >= 0)
        check($sformatf("v%0d_latency", v), cyc, vecs[v].e_cyc);
      check($sformatf("v%0d_err", v), {31'b0, err},
            {31'b0, vecs[v].e_err});
      check($sformatf("v%0d_words", v), {16'b0, words_done},
            vecs[v].e_words);
      check($sformatf("v%0d_csum", v), checksum,
            CSUM_ON ? vecs[v].e_csum : 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulses", v), mon_done, 1);
      check($sformatf("v%0d_reqs", v), mon_reqs, vecs[v].e_reqs);
      check($sformatf("v%0d_writes", v), mon_wrs, vecs[v].e_words);
      check($sformatf("v%0d_stable", v), mon_unst, 0);
      if (vecs[v].e_reqs == 0)
        check($sformatf("v%0d_no_valid", v), mon_rv, 0);
      if (vecs[v].e_reqs > 0)
        check($sformatf("v%0d_rd_addr", v), first_rd, vecs[v].e_rd0);
      if (vecs[v].e_words > 0)
        check($sformatf("v%0d_wr_addr", v), first_wr, vecs[v].e_wr0);
      for (int i = 0; i < vecs[v].e_words; i++)
        check($sformatf("v%0d_mem%0d", v, i),
              mem[(vecs[v].dst >> 2) + i], 32'h11111111 * (i + 1));
    end

    // reset while a delayed read is outstanding
    rw = 0;
    dw = 5;
    start_cmd(32'h0, 32'h500, 16'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("mid_rst_req_valid", {31'b0, bus.req_valid}, 32'd0);
    check("mid_rst_req_addr", bus.req_addr, 32'd0);
    check("mid_rst_req_wdata", bus.req_wdata, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_csum", checksum, 32'd0);
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("stale_no_valid", mon_rv, 0);
    check("stale_no_done", mon_done, 0);
    check("stale_words", {16'b0, words_done}, 32'd0);
    check("stale_err", {31'b0, err}, 32'd0);
    check("stale_mem", mem[32'h500 >> 2], 32'hDEAD0140);

    dw = 0;
    clear_mon();
    start_cmd(32'h0, 32'h600, 16'd2);
    wait_done(cyc);
    check("post_rst_latency", cyc, 9);
    check("post_rst_words", {16'b0, words_done}, 32'd2);
    check("post_rst_err", {31'b0, err}, 32'd0);
    check("post_rst_csum", checksum, CSUM_ON ? 32'h33333333 : 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_mem0", mem[32'h600 >> 2], 32'h11111111);
    check("post_rst_mem1", mem[(32'h600 >> 2) + 1], 32'h22222222);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

Word-granular memory-to-memory copy engine acting as the initiator on the single-outstanding `req_*`/`resp_*` memory port. It accepts one copy command (source, destination, word count) and performs a read-then-write per word against a memory responder that may insert wait cycles. It reports completion, the number of words moved, and bus errors. It sits between a control/CSR front end and the shared memory.

## Interface
- `ADDR_WIDTH`, default 32: memory address width.
- `LEN_WIDTH`, default 16: width of the word-count field.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: engine idle; the command is accepted when `cmd_valid && cmd_ready`.
- `cmd_src` in ADDR_WIDTH: source byte address; bits [1:0] are ignored (forced to 0).
- `cmd_dst` in ADDR_WIDTH: destination byte address; bits [1:0] are ignored.
- `cmd_len` in LEN_WIDTH: number of 32-bit words to copy.
- `req_ready` in 1: memory can accept a request.
- `req_valid` out 1: request valid.
- `req_addr` out ADDR_WIDTH: request address.
- `req_wen` out 1: 1 for a write, 0 for a read.
- `req_wdata` out 32: write data.
- `resp_valid` in 1: response valid. Writes also produce a response.
- `resp_error` in 1: response carries an error.
- `resp_rdata` in 32: read data.
- `done` out 1: one-cycle pulse when a command finishes, whether it completed or aborted.
- `err` out 1: the last command aborted on `resp_error`. Held until the next command is accepted.
- `words_done` out LEN_WIDTH: count of words fully written for the current or last command.
- `checksum` out 32: see Configuration.

## Operation
- States: `S_IDLE`, `S_RD_REQ`, `S_RD_WAIT`, `S_WR_REQ`, `S_WR_WAIT`, `S_DONE`.
- **S_IDLE**
  - `cmd_ready=1`.
  - On accept: latch src/dst (low 2 bits zeroed) and len; clear `err`, `words_done` and `checksum`.
  - Next state is `S_RD_REQ`, or `S_DONE` if `cmd_len==0`.
- **S_RD_REQ**
  - Drive `req_valid=1`, `req_wen=0`, `req_addr=src`.
  - Stay until `req_ready`; all request fields are held stable while waiting.
  - Next state is `S_RD_WAIT`.
- **S_RD_WAIT**
  - On `resp_valid` with `resp_error`: set `err`, go to `S_DONE`.
  - On `resp_valid` without error: capture `resp_rdata` into the data register, go to `S_WR_REQ`.
- **S_WR_REQ**
  - Drive `req_valid=1`, `req_wen=1`, `req_addr=dst`, `req_wdata` = data register.
  - Hold until `req_ready`, then go to `S_WR_WAIT`.
- **S_WR_WAIT**
  - On `resp_valid` with `resp_error`: set `err`, go to `S_DONE`.
  - On `resp_valid` without error:
    - `words_done++`, `src+=4`, `dst+=4`.
    - Go to `S_DONE` if `words_done+1==len`, else `S_RD_REQ`.
- **S_DONE**
  - `done=1` for exactly one cycle, then `S_IDLE`.
- Response and address rules:
  - `resp_valid` in any state other than `S_RD_WAIT`/`S_WR_WAIT` is ignored (stale response).
  - `resp_rdata` is treated as opaque data; no byte reordering.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH; a copy crossing the top of the address space wraps to 0 silently.
- At most one request is outstanding. `req_valid` is deasserted in WAIT states, IDLE and DONE.
- Outputs when not driving a request: `req_addr`, `req_wen` and `req_wdata` may hold their last values; only `req_valid` is significant.

## Timing
- Reset values: state `S_IDLE`.
  - 1: `cmd_ready`.
  - 0: `req_valid`, `req_wen`, `req_addr`, `req_wdata`, `done`, `err`, `words_done`, `checksum`.
- Against a zero-delay responder (always ready, response the cycle after acceptance), each word takes 4 cycles: RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - An N-word copy: `done` asserts 4N+1 cycles after the accept edge.
  - A zero-length copy: `done` asserts the cycle after accept.
- Wait-state responder: the REQ state stalls while `req_ready=0`, and the WAIT state stalls while `resp_valid=0`. There is no timeout.
- Reset asserted mid-command: return immediately to `S_IDLE` with all outputs at reset values.
  - A response arriving later for the abandoned request is ignored per the stale-response rule.
- `cmd_valid` while busy is not accepted (`cmd_ready=0`).

## Configuration
- `DMA_CHECKSUM_EN` defined:
  - `checksum` is the wrapping 32-bit sum of every non-error read datum of the current command.
  - It updates on read capture and is cleared on command accept.
- `DMA_CHECKSUM_EN` not defined:
  - The `checksum` port still exists and is tied to 0.
  - No accumulator logic is present.

## Structure
- Shared package `dma_pkg`:
  - state enum `dma_state_t`;
  - struct `dma_cmd_t` {src, dst, len}, parameterised via package constants `DMA_ADDR_WIDTH=32`, `DMA_LEN_WIDTH=16`;
  - constant `DMA_WORD_BYTES=4`.
- Single module, no sub-module needed.

## Test plan
- Zero-delay memory preloaded with mem[0..3]=0x11111111..0x44444444; cmd src=0x0, dst=0x100, len=4.
  - Words at 0x100..0x10C match the source.
  - `done` arrives 17 cycles after accept; `words_done=4`, `err=0`.
  - With `DMA_CHECKSUM_EN`: checksum=0xAAAAAAAA.
- Responder with 3 wait cycles; len=2.
  - `req_valid`, `req_addr` and `req_wdata` stay stable while `req_ready=0`.
  - Copy is correct; `done` pulses once.
- cmd_len=0.
  - No `req_valid` ever asserts; `done` pulses the cycle after accept; `words_done=0`.
- src=0x00010000 (out of range for a 16-bit-word memory), len=3.
  - `resp_error` on the first read gives `err=1`, `words_done=0`.
  - No write is issued; `done` pulses.
- cmd src=0x3, dst=0x102.
  - Requests go to 0x0 and 0x100 (low bits ignored).
- Assert `rst_n=0` during `S_RD_WAIT` of a delayed read.
  - Outputs return to reset values; a late `resp_valid` is ignored.
  - A new cmd afterwards completes correctly.
